control_sequencer: RTL and testbench

//  Multi-cycle sequencer for the CPU datapath. Fetches each instruction into an internal IR and

---
 rtl/control_sequencer_if.sv | 27 ++
 rtl/control_sequencer.sv | 101 ++++++++++
 tb/tb_control_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Bus between the control sequencer and its datapath/decoder environment.
// mem_ready is the valid for instr; the sequencer is ready whenever it sits in FETCH with hold low, and ir_load marks the transfer.
interface control_sequencer_if;
  logic        hold;
  logic [31:0] instr;
  logic        mem_ready;
  logic [4:0]  alu_status;
  logic [32:0] dec_ctrl;
  logic [31:0] ir;
  logic [1:0]  step;
  logic [4:0]  status;
  logic [32:0] ctrl;
  logic        ir_load;
  logic        halted;
  logic        fault;
  logic [1:0]  dbg_phase;

  modport master (
    input  hold, instr, mem_ready, alu_status, dec_ctrl,
    output ir, step, status, ctrl, ir_load, halted, fault, dbg_phase
  );

  modport slave (
    output hold, instr, mem_ready, alu_status, dec_ctrl,
    input  ir, step, status, ctrl, ir_load, halted, fault, dbg_phase
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle CPU sequencer: fetches into IR, steps the per-class decoders, selects the
// datapath control word, and owns status flags, halt detection and fetch/exec watchdogs.
module control_sequencer #(
  parameter int MAX_EXEC_CYCLES = 4,
  parameter int FETCH_TIMEOUT   = 15
) (
  input logic                 clock,
  input logic                 reset_n,
  control_sequencer_if.master bus
);
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } phase_t;

  localparam int EW = $clog2(MAX_EXEC_CYCLES + 1);
  localparam int FW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [EW-1:0] EXEC_LAST  = EW'(MAX_EXEC_CYCLES - 1);
  localparam logic [FW-1:0] FETCH_LAST = FW'(FETCH_TIMEOUT - 1);
  localparam logic [32:0] FETCH_WORD = 33'h0_0000_0100;
  // reg_w, ram_w, pc_fs and status_load: everything that commits state downstream
  localparam logic [32:0] WRITE_MASK = 33'h0_0000_02B4;

  phase_t        phase;
  logic [1:0]    step;
  logic [31:0]   ir;
  logic [4:0]    status;
  logic [EW-1:0] exec_cnt;
  logic [FW-1:0] fetch_cnt;
  logic [1:0]    ns;
  logic [32:0]   ctrl_sel;

  assign ns = bus.dec_ctrl[1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase     <= FETCH;
      step      <= 2'b00;
      ir        <= 32'h0;
      status    <= 5'b0;
      exec_cnt  <= '0;
      fetch_cnt <= '0;
    end else if (!bus.hold) begin
      case (phase)
        FETCH: begin
          if (bus.mem_ready) begin
            ir        <= bus.instr;
            step      <= 2'b00;
            exec_cnt  <= '0;
            fetch_cnt <= '0;
            phase     <= (bus.instr == 32'h0) ? HALT : EXEC;
          end else if (fetch_cnt == FETCH_LAST) begin
            fetch_cnt <= '0;
            phase     <= FAULT;
          end else begin
            fetch_cnt <= fetch_cnt + 1'b1;
          end
        end
        EXEC: begin
          if (bus.dec_ctrl[2]) status <= bus.alu_status;
          if (ns == 2'b00) begin
            exec_cnt <= '0;
            phase    <= FETCH;
          end else if (exec_cnt == EXEC_LAST) begin
            exec_cnt <= '0;
            phase    <= FAULT;
          end else begin
            step     <= ns;
            exec_cnt <= exec_cnt + 1'b1;
          end
        end
        HALT:  ;
        FAULT: ;
        default: ;
      endcase
    end
  end

  always_comb begin
    ctrl_sel = '0;
    case (phase)
      FETCH: begin
        ctrl_sel = FETCH_WORD;
        if (bus.mem_ready) ctrl_sel[5:4] = 2'b01;
      end
      EXEC:    ctrl_sel = bus.dec_ctrl;
      default: ctrl_sel = '0;
    endcase
  end

  assign bus.ctrl      = bus.hold ? (ctrl_sel & ~WRITE_MASK) : ctrl_sel;
  assign bus.ir_load   = (phase == FETCH) && bus.mem_ready && !bus.hold;
  assign bus.ir        = ir;
  assign bus.step      = step;
  assign bus.status    = status;
  assign bus.halted    = (phase == HALT);
  assign bus.fault     = (phase == FAULT);
  assign bus.dbg_phase = phase;
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (default limits and tight limits) driven by
// the same directed then random stimulus, compared every cycle against a behavioural model.
module tb_control_sequencer;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        mem_ready = 1'b0;
  logic [4:0]  alu_status = 5'b0;
  logic [32:0] dec_ctrl = 33'h0;

  int tests = 0;
  int failed = 0;

  always #5 clock = ~clock;

  control_sequencer_if bus_a();
  control_sequencer_if bus_b();

  control_sequencer #(.MAX_EXEC_CYCLES(4), .FETCH_TIMEOUT(15)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a.master));
  control_sequencer #(.MAX_EXEC_CYCLES(2), .FETCH_TIMEOUT(5)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b.master));

  assign bus_a.hold = hold;
  assign bus_a.instr = instr;
  assign bus_a.mem_ready = mem_ready;
  assign bus_a.alu_status = alu_status;
  assign bus_a.dec_ctrl = dec_ctrl;
  assign bus_b.hold = hold;
  assign bus_b.instr = instr;
  assign bus_b.mem_ready = mem_ready;
  assign bus_b.alu_status = alu_status;
  assign bus_b.dec_ctrl = dec_ctrl;

  logic [32:0] act_ctrl[2];
  logic [31:0] act_ir[2];
  logic [1:0]  act_step[2];
  logic [4:0]  act_status[2];
  logic        act_ir_load[2];
  logic        act_halted[2];
  logic        act_fault[2];
  assign act_ctrl[0] = bus_a.ctrl;       assign act_ctrl[1] = bus_b.ctrl;
  assign act_ir[0] = bus_a.ir;           assign act_ir[1] = bus_b.ir;
  assign act_step[0] = bus_a.step;       assign act_step[1] = bus_b.step;
  assign act_status[0] = bus_a.status;   assign act_status[1] = bus_b.status;
  assign act_ir_load[0] = bus_a.ir_load; assign act_ir_load[1] = bus_b.ir_load;
  assign act_halted[0] = bus_a.halted;   assign act_halted[1] = bus_b.halted;
  assign act_fault[0] = bus_a.fault;     assign act_fault[1] = bus_b.fault;

  // Behavioural model: per instance, flags for where the instruction is plus plain counts.
  int          lim_exec[2]  = '{4, 2};
  int          lim_fetch[2] = '{15, 5};
  logic [31:0] m_ir[2]      = '{32'h0, 32'h0};
  logic [1:0]  m_step[2]    = '{2'b0, 2'b0};
  logic [4:0]  m_status[2]  = '{5'b0, 5'b0};
  bit          m_exec[2]    = '{1'b0, 1'b0};
  bit          m_halted[2]  = '{1'b0, 1'b0};
  bit          m_faulted[2] = '{1'b0, 1'b0};
  int          m_waited[2]  = '{0, 0};
  int          m_execs[2]   = '{0, 0};

  task automatic model_step(input int i);
    if (!reset_n) begin
      m_ir[i] = 32'h0; m_step[i] = 2'b0; m_status[i] = 5'b0;
      m_exec[i] = 1'b0; m_halted[i] = 1'b0; m_faulted[i] = 1'b0;
      m_waited[i] = 0; m_execs[i] = 0;
    end else if (hold || m_halted[i] || m_faulted[i]) begin
    end else if (!m_exec[i]) begin
      if (mem_ready) begin
        m_ir[i] = instr; m_step[i] = 2'b0; m_waited[i] = 0; m_execs[i] = 0;
        if (instr == 32'h0) m_halted[i] = 1'b1;
        else m_exec[i] = 1'b1;
      end else begin
        m_waited[i]++;
        if (m_waited[i] == lim_fetch[i]) m_faulted[i] = 1'b1;
      end
    end else begin
      if (dec_ctrl[2]) m_status[i] = alu_status;
      m_execs[i]++;
      if (dec_ctrl[1:0] == 2'b00) begin
        m_exec[i] = 1'b0; m_execs[i] = 0;
      end else if (m_execs[i] == lim_exec[i]) begin
        m_faulted[i] = 1'b1;
      end else begin
        m_step[i] = dec_ctrl[1:0];
      end
    end
  endtask

  function automatic logic [32:0] model_ctrl(input int i);
    logic [32:0] w;
    if (m_halted[i] || m_faulted[i]) w = '0;
    else if (m_exec[i]) w = dec_ctrl;
    else begin
      w = '0;
      w[8] = 1'b1;
      if (mem_ready) w[5:4] = 2'b01;
    end
    if (hold) begin
      w[9] = 1'b0; w[7] = 1'b0; w[2] = 1'b0; w[5:4] = 2'b00;
    end
    return w;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    model_step(0);
    model_step(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every falling edge, both instances against the model.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      string p;
      p = (i == 0) ? "a" : "b";
      check({p, " ctrl"}, 64'(act_ctrl[i]), 64'(model_ctrl(i)));
      check({p, " ir_load"}, 64'(act_ir_load[i]),
            64'(!m_halted[i] && !m_faulted[i] && !m_exec[i] && mem_ready && !hold));
      check({p, " ir"}, 64'(act_ir[i]), 64'(m_ir[i]));
      check({p, " step"}, 64'(act_step[i]), 64'(m_step[i]));
      check({p, " status"}, 64'(act_status[i]), 64'(m_status[i]));
      check({p, " halted"}, 64'(act_halted[i]), 64'(m_halted[i]));
      check({p, " fault"}, 64'(act_fault[i]), 64'(m_faulted[i]));
    end
  end

  task automatic drive(input logic h, input logic mr, input logic [31:0] in,
                       input logic [4:0] as, input logic [32:0] dc);
    hold = h; mem_ready = mr; instr = in; alu_status = as; dec_ctrl = dc;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int starve;
    logic [32:0] dc;
    starve = 0;

    // Reset values
    drive(0, 0, 32'h0, 5'b0, 33'h0);
    repeat (3) next_cycle();
    @(negedge clock);
    check("rst ctrl", 64'(bus_a.ctrl), 64'h100);
    check("rst ir", 64'(bus_a.ir), 64'h0);
    check("rst status", 64'(bus_a.status), 64'h0);
    check("rst flags", 64'({bus_a.halted, bus_a.fault}), 64'h0);
    next_cycle();
    reset_n = 1'b1;

    // Single-cycle op
    drive(0, 1, 32'h9100_0441, 5'b0, 33'h1_0000_0200);
    @(negedge clock);
    check("t2 fetch ctrl", 64'(bus_a.ctrl), 64'h110);
    check("t2 ir_load", 64'(bus_a.ir_load), 64'h1);
    next_cycle();
    drive(0, 0, 32'h0, 5'b0, 33'h1_0000_0200);
    @(negedge clock);
    check("t2 ir", 64'(bus_a.ir), 64'h9100_0441);
    check("t2 exec ctrl", 64'(bus_a.ctrl), 64'h1_0000_0200);
    next_cycle();
    @(negedge clock);
    check("t2 back to fetch", 64'(bus_a.ctrl), 64'h100);

    // Multi-cycle with status load; instance b faults on its second exec cycle
    next_cycle();
    drive(0, 1, 32'h1234_5678, 5'b0, 33'h0);
    next_cycle();
    drive(0, 0, 32'h0, 5'b10110, 33'h0_0000_0005);
    @(negedge clock);
    check("t3 step0", 64'(bus_a.step), 64'h0);
    next_cycle();
    drive(0, 0, 32'h0, 5'b01001, 33'h0_0000_0002);
    @(negedge clock);
    check("t3 step1", 64'(bus_a.step), 64'h1);
    check("t4 status load", 64'(bus_a.status), 64'h16);
    next_cycle();
    drive(0, 0, 32'h0, 5'b01001, 33'h0);
    @(negedge clock);
    check("t3 step2", 64'(bus_a.step), 64'h2);
    check("t4 status kept", 64'(bus_a.status), 64'h16);
    check("t3 b fault", 64'(bus_b.fault), 64'h1);
    next_cycle();
    @(negedge clock);
    check("t3 a fetch", 64'({bus_a.fault, bus_a.ctrl}), 64'h100);

    // Hold in FETCH with data ready
    next_cycle();
    drive(1, 1, 32'h5555_0000, 5'b0, 33'h0);
    @(negedge clock);
    check("hold fetch ir_load", 64'(bus_a.ir_load), 64'h0);
    check("hold fetch ctrl", 64'(bus_a.ctrl), 64'h100);
    next_cycle();
    drive(0, 0, 32'h0, 5'b0, 33'h0);
    @(negedge clock);
    check("hold fetch ir", 64'(bus_a.ir), 64'h1234_5678);

    // Hold during EXEC, then resume
    next_cycle();
    drive(0, 1, 32'hABCD_0001, 5'b0, 33'h0);
    next_cycle();
    drive(1, 0, 32'h0, 5'b00111, 33'h1_0000_02A5);
    @(negedge clock);
    check("t5 masked ctrl", 64'(bus_a.ctrl), 64'h1_0000_0001);
    next_cycle();
    @(negedge clock);
    check("t5 frozen", 64'({bus_a.step, bus_a.status}), 64'({2'b00, 5'b10110}));
    next_cycle();
    hold = 1'b0;
    @(negedge clock);
    check("t5 resume ctrl", 64'(bus_a.ctrl), 64'h1_0000_02A5);
    next_cycle();
    drive(0, 0, 32'h0, 5'b0, 33'h0);
    @(negedge clock);
    check("t5 after", 64'({bus_a.step, bus_a.status}), 64'({2'b01, 5'b00111}));
    next_cycle();

    // Reset mid-EXEC
    drive(0, 1, 32'h0000_0F0F, 5'b0, 33'h0);
    next_cycle();
    drive(0, 0, 32'h0, 5'b11111, 33'h0_0000_0005);
    next_cycle();
    reset_n = 1'b0;
    drive(0, 0, 32'h0, 5'b11111, 33'h0_0000_0005);
    @(negedge clock);
    check("t1 ctrl", 64'(bus_a.ctrl), 64'h100);
    check("t1 regs", 64'({bus_a.ir, bus_a.status, bus_a.step}), 64'h0);
    next_cycle();
    reset_n = 1'b1;

    // Halt on zero instruction
    drive(0, 1, 32'h0, 5'b0, 33'h0);
    next_cycle();
    drive(0, 1, 32'h5, 5'b11111, 33'h1_FFFF_FFFF);
    repeat (3) next_cycle();
    @(negedge clock);
    check("t6 halted", 64'(bus_a.halted), 64'h1);
    check("t6 halt ctrl", 64'(bus_a.ctrl), 64'h0);
    next_cycle();
    reset_n = 1'b0;
    drive(0, 0, 32'h0, 5'b0, 33'h0);
    next_cycle();
    reset_n = 1'b1;

    // Fetch timeout
    repeat (14) next_cycle();
    @(negedge clock);
    check("t6 no fault at 14", 64'(bus_a.fault), 64'h0);
    next_cycle();
    @(negedge clock);
    check("t6 fault at 15", 64'(bus_a.fault), 64'h1);
    check("t6 fault ctrl", 64'(bus_a.ctrl), 64'h0);
    next_cycle();
    reset_n = 1'b0;
    next_cycle();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      reset_n = 1'b1;
      if ((m_halted[0] || m_faulted[0] || m_halted[1] || m_faulted[1]) &&
          $urandom_range(0, 9) == 0) reset_n = 1'b0;
      if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
      if (starve > 0) begin
        mem_ready = 1'b0;
        starve--;
      end else begin
        mem_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 40) == 0) starve = $urandom_range(3, 18);
      end
      hold = ($urandom_range(0, 7) == 0);
      instr = ($urandom_range(0, 50) == 0) ? 32'h0 : 32'($urandom);
      alu_status = 5'($urandom_range(0, 31));
      dc = {1'($urandom_range(0, 1)), 32'($urandom)};
      dc[1:0] = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      dec_ctrl = dc;
      next_cycle();
    end
    reset_n = 1'b1;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
